// File: rtl/letter_select.sv
// Letter selector for the Enigma front panel: synchronizes up/down/enter toggle levels,
// steps a wrapping letter index and offers it over valid/ready. Optional: AUTO_ADVANCE_EN.
module letter_select #(
  parameter int NUM_LETTERS = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_tgl,
  input  logic       down_tgl,
  input  logic       enter_tgl,
  output logic [4:0] letter,
  output logic [4:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       press_dropped
);

  localparam logic [4:0] LAST = 5'(NUM_LETTERS - 1);
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PW = $clog2(PRIME_CYCLES + 1);

  typedef enum logic {SELECT, OFFER} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync_q [SYNC_STAGES];
  logic [2:0]      sync_d [SYNC_STAGES];
  logic [2:0]      prev_q, prev_d;
  logic [PW-1:0]   prime_cnt_q, prime_cnt_d;
  logic [4:0]      letter_q, letter_d;
  logic [4:0]      char_out_q, char_out_d;
  logic            char_valid_q, char_valid_d;
  logic            press_dropped_q, press_dropped_d;

  logic [2:0]      sync_out;
  logic [2:0]      press;
  logic            primed;
  logic            up_p, down_p, enter_p;
  logic            accept;
  logic [4:0]      letter_inc, letter_dec;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign primed   = (prime_cnt_q == PW'(PRIME_CYCLES));
  assign press    = primed ? (sync_out ^ prev_q) : 3'b000;
  assign up_p     = press[0];
  assign down_p   = press[1];
  assign enter_p  = press[2];
  assign accept   = char_valid_q && char_ready;

  assign letter_inc = (letter_q == LAST) ? 5'd0 : letter_q + 5'd1;
  assign letter_dec = (letter_q == 5'd0) ? LAST : letter_q - 5'd1;

  // Priming spans the synchronizer fill, so a level already high at reset release
  // is absorbed into prev instead of being seen as a press.
  always_comb begin
    sync_d[0] = {enter_tgl, down_tgl, up_tgl};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d      = sync_out;
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 3'b000;
      end
      prev_q      <= 3'b000;
      prime_cnt_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q      <= prev_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SELECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SELECT:  if (enter_p) state_d = OFFER;
      OFFER:   if (accept)  state_d = SELECT;
      default: state_d = SELECT;
    endcase
  end

  always_comb begin
    letter_d        = letter_q;
    char_out_d      = char_out_q;
    char_valid_d    = char_valid_q;
    press_dropped_d = 1'b0;
    case (state_q)
      SELECT: begin
        if (up_p && !down_p) begin
          letter_d = letter_inc;
        end else if (down_p && !up_p) begin
          letter_d = letter_dec;
        end
        if (enter_p) begin
          char_out_d   = letter_q;
          char_valid_d = 1'b1;
        end
      end
      OFFER: begin
        press_dropped_d = |press;
        if (accept) begin
          char_valid_d = 1'b0;
`ifdef AUTO_ADVANCE_EN
          letter_d     = letter_inc;
`else
          letter_d     = letter_q;
`endif
        end
      end
      default: begin
        char_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      letter_q        <= 5'd0;
      char_out_q      <= 5'd0;
      char_valid_q    <= 1'b0;
      press_dropped_q <= 1'b0;
    end else begin
      letter_q        <= letter_d;
      char_out_q      <= char_out_d;
      char_valid_q    <= char_valid_d;
      press_dropped_q <= press_dropped_d;
    end
  end

  assign letter        = letter_q;
  assign char_out      = char_out_q;
  assign char_valid    = char_valid_q;
  assign press_dropped = press_dropped_q;

endmodule
